memstage_ctrl: RTL and testbench
================================

Name: memstage_ctrl

Overview:
- Sequences the MEM stage of the 5-stage semiMIPS pipeline, driven from the EX/MEM pipeline register outputs.
- Runs the data-memory request/acknowledge handshake and holds the whole pipeline while an access is outstanding.
- Resolves branches and jumps latched in EX/MEM, producing PC-select and flush pulses.
- Detects memory timeouts and counts stall cycles for performance monitoring.

Parameters:
- DWIDTH, 32, data width of the read-data path
- TIMEOUT, 16, maximum cycles waiting for dmem_ack before the error state (≥2)
- CWIDTH, 32, stall-cycle counter width

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- exmem_valid  in  1  EX/MEM holds a real instruction (0 = bubble)
- memrd  in  1  load, from EX/MEM
- memwr  in  1  store, from EX/MEM
- bbeq, bbne, bblez, bbgtz, jump  in  1 each  branch/jump decode, from EX/MEM
- zero, negative  in  1 each  ALU flags, from EX/MEM
- dmem_req  out  1  data-memory request
- dmem_we  out  1  write enable, valid with dmem_req
- dmem_ack  in  1  memory completes the access this cycle
- dmem_rdata  in  DWIDTH  load data, valid with dmem_ack
- rdata_q  out  DWIDTH  registered load data for the MEM/WB register
- stall  out  1  freeze PC and all pipeline registers
- pcsrc  out  2  00 = PC+4, 01 = branch address, 10 = jump address
- flush_ifid, flush_idex, flush_exmem  out  1 each  bubble-insert pulses
- bus_err  out  1  sticky memory-timeout flag
- stall_cnt  out  CWIDTH  saturating count of stall cycles

Behaviour:
- Reset (asynchronous): state=IDLE. Outputs and counters all 0: dmem_req, stall, pcsrc, every flush, bus_err, rdata_q, stall_cnt. A reset mid-access drops dmem_req immediately; a late ack is ignored.
- memop = exmem_valid & (memrd | memwr). If memrd and memwr are both set, treat as a store.
- FSM states: IDLE, WAIT, ERR.
- IDLE with memop:
  - dmem_req=1 and dmem_we=memwr, both combinational, same cycle.
  - If dmem_ack is also 1 (zero-wait memory): stall=0, rdata_q<=dmem_rdata on a load, stay in IDLE.
  - Otherwise: stall=1, next state WAIT, wait counter loaded with 1.
- WAIT:
  - dmem_req=1 and stall=1 held; the EX/MEM inputs are frozen by the stall.
  - On dmem_ack: stall=0 that cycle, capture rdata_q on a load, next state IDLE.
  - Otherwise increment the wait counter. When it reaches TIMEOUT with no ack: next state ERR.
- ERR: dmem_req=0, stall=0, bus_err=1. The instruction retires with rdata_q unchanged. Leaves only through rst.
- Branch resolution is combinational, gated by exmem_valid & ~stall:
  - taken = bbeq&zero | bbne&~zero | bblez&(zero|negative) | bbgtz&~zero&~negative
  - pcsrc = 10 if jump; else 01 if taken; else 00. Jump has priority over branch.
  - If jump or taken: flush_ifid, flush_idex, flush_exmem are all 1 for exactly that cycle.
- stall has priority over flush. While stall=1, pcsrc=00 and no flush is issued.
- stall_cnt increments every cycle stall=1 and saturates at all-ones.
- Branch and memop are never both set in one instruction. If they are, memop wins, and the branch resolves in the un-stalled completion cycle.

Decomposition:
- Shared package memctrl_pkg holds:
  - FSM state encoding: IDLE=2'd0, WAIT=2'd1, ERR=2'd2
  - pcsrc constants: PC_SEQ=2'b00, PC_BR=2'b01, PC_JMP=2'b10
- One sub-module, branch_resolve: purely combinational taken/pcsrc logic, reusable by a future early-branch ID stage.

Test Plan:
- Load with ack in the same cycle, dmem_rdata=32'hDEADBEEF -> dmem_req high 1 cycle, stall never asserted, rdata_q=DEADBEEF next cycle, stall_cnt=0.
- Store with ack 3 cycles after request -> dmem_we=1, stall high exactly 3 cycles, stall_cnt=3, FSM back in IDLE.
- bbeq with zero=1 -> pcsrc=01 and all three flushes high for 1 cycle.
- bbgtz with negative=1 -> pcsrc=00, no flush.
- jump=1 together with bbne, zero=0 -> pcsrc=10.
- Load never acked, TIMEOUT=16 -> stall drops and bus_err rises after 16 stalled cycles. bus_err stays set while later instructions flow, and clears only on rst. A second test asserts rst in WAIT: dmem_req falls asynchronously and a late ack has no effect.

Source files
------------

// File: rtl/memctrl_pkg.sv
// Shared encodings for the semiMIPS MEM-stage controller.
package memctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ERR  = 2'd2
   } state_t;

   localparam logic [1:0] PC_SEQ = 2'b00;
   localparam logic [1:0] PC_BR  = 2'b01;
   localparam logic [1:0] PC_JMP = 2'b10;

endpackage

// File: rtl/branch_resolve.sv
// Combinational branch/jump resolution: taken decision, PC-select and redirect (flush) request.
module branch_resolve
   import memctrl_pkg::*;
(
   input  logic       i_en,
   input  logic       i_bbeq,
   input  logic       i_bbne,
   input  logic       i_bblez,
   input  logic       i_bbgtz,
   input  logic       i_jump,
   input  logic       i_zero,
   input  logic       i_negative,
   output logic [1:0] o_pcsrc,
   output logic       o_redirect
);

   logic w_taken;

   assign w_taken = (i_bbeq  & i_zero)
                  | (i_bbne  & ~i_zero)
                  | (i_bblez & (i_zero | i_negative))
                  | (i_bbgtz & ~i_zero & ~i_negative);

   // NOTE: every output gets a default first so no path through the block infers a latch.
   always_comb begin
      o_pcsrc    = PC_SEQ;
      o_redirect = 1'b0;
      if (i_en) begin
         if (i_jump) begin
            o_pcsrc    = PC_JMP;
            o_redirect = 1'b1;
         end else if (w_taken) begin
            o_pcsrc    = PC_BR;
            o_redirect = 1'b1;
         end
      end
   end

endmodule

// File: rtl/memstage_ctrl.sv
// MEM-stage sequencer: data-memory handshake with pipeline stall, timeout error state,
// branch/jump redirect and a saturating stall-cycle counter.
module memstage_ctrl
   import memctrl_pkg::*;
#(
   parameter int DWIDTH  = 32,
   parameter int TIMEOUT = 16,
   parameter int CWIDTH  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              exmem_valid,
   input  logic              memrd,
   input  logic              memwr,
   input  logic              bbeq,
   input  logic              bbne,
   input  logic              bblez,
   input  logic              bbgtz,
   input  logic              jump,
   input  logic              zero,
   input  logic              negative,
   output logic              dmem_req,
   output logic              dmem_we,
   input  logic              dmem_ack,
   input  logic [DWIDTH-1:0] dmem_rdata,
   output logic [DWIDTH-1:0] rdata_q,
   output logic              stall,
   output logic [1:0]        pcsrc,
   output logic              flush_ifid,
   output logic              flush_idex,
   output logic              flush_exmem,
   output logic              bus_err,
   output logic [CWIDTH-1:0] stall_cnt
);

   localparam int TW = $clog2(TIMEOUT);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [TW-1:0]     r_wait_cnt;
   logic [TW-1:0]     w_wait_cnt_nxt;
   logic [DWIDTH-1:0] r_rdata_q;
   logic [CWIDTH-1:0] r_stall_cnt;
   logic              w_memop;
   logic              w_load;
   logic              w_req;
   logic              w_stall;
   logic              w_capture;
   logic              w_redirect;

   assign w_memop = exmem_valid & (memrd | memwr);
   assign w_load  = memrd & ~memwr;

   always_comb begin
      w_state_nxt    = r_state;
      w_wait_cnt_nxt = r_wait_cnt;
      w_req          = 1'b0;
      w_stall        = 1'b0;
      w_capture      = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_memop) begin
               w_req = 1'b1;
               if (dmem_ack) begin
                  w_capture = w_load;
               end else begin
                  w_stall        = 1'b1;
                  w_state_nxt    = WAIT;
                  w_wait_cnt_nxt = TW'(1);
               end
            end
         end
         WAIT: begin
            w_req = 1'b1;
            if (dmem_ack) begin
               w_capture   = w_load;
               w_state_nxt = IDLE;
            end else begin
               w_stall = 1'b1;
               // The IDLE request cycle plus WAIT cycles 1..TIMEOUT-1 make TIMEOUT stalled cycles.
               if (r_wait_cnt == TW'(TIMEOUT - 1)) w_state_nxt = ERR;
               else                                w_wait_cnt_nxt = r_wait_cnt + 1'b1;
            end
         end
         ERR:     ;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Reset gates the combinational handshake so an in-flight request drops immediately.
   assign dmem_req = w_req & ~rst;
   assign dmem_we  = dmem_req & memwr;
   assign stall    = w_stall & ~rst;
   assign bus_err  = (r_state == ERR);

   branch_resolve u_branch_resolve (
      .i_en       (exmem_valid & ~stall & ~rst),
      .i_bbeq     (bbeq),
      .i_bbne     (bbne),
      .i_bblez    (bblez),
      .i_bbgtz    (bbgtz),
      .i_jump     (jump),
      .i_zero     (zero),
      .i_negative (negative),
      .o_pcsrc    (pcsrc),
      .o_redirect (w_redirect)
   );

   assign flush_ifid  = w_redirect;
   assign flush_idex  = w_redirect;
   assign flush_exmem = w_redirect;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_wait_cnt  <= '0;
         r_rdata_q   <= '0;
         r_stall_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_cnt_nxt;
         if (w_capture) r_rdata_q <= dmem_rdata;
         if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign rdata_q   = r_rdata_q;
   assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_memstage_ctrl.sv
// Self-checking bench for memstage_ctrl: zero-wait vector table plus multi-cycle handshake,
// timeout and reset sequences.
module tb_memstage_ctrl;

   localparam int DWIDTH  = 32;
   localparam int TIMEOUT = 16;
   localparam int CWIDTH  = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              exmem_valid, memrd, memwr;
   logic              bbeq, bbne, bblez, bbgtz, jump, zero, negative;
   logic              dmem_req, dmem_we, dmem_ack;
   logic [DWIDTH-1:0] dmem_rdata, rdata_q;
   logic              stall;
   logic [1:0]        pcsrc;
   logic              flush_ifid, flush_idex, flush_exmem;
   logic              bus_err;
   logic [CWIDTH-1:0] stall_cnt;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   memstage_ctrl #(.DWIDTH(DWIDTH), .TIMEOUT(TIMEOUT), .CWIDTH(CWIDTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .exmem_valid (exmem_valid),
      .memrd       (memrd),
      .memwr       (memwr),
      .bbeq        (bbeq),
      .bbne        (bbne),
      .bblez       (bblez),
      .bbgtz       (bbgtz),
      .jump        (jump),
      .zero        (zero),
      .negative    (negative),
      .dmem_req    (dmem_req),
      .dmem_we     (dmem_we),
      .dmem_ack    (dmem_ack),
      .dmem_rdata  (dmem_rdata),
      .rdata_q     (rdata_q),
      .stall       (stall),
      .pcsrc       (pcsrc),
      .flush_ifid  (flush_ifid),
      .flush_idex  (flush_idex),
      .flush_exmem (flush_exmem),
      .bus_err     (bus_err),
      .stall_cnt   (stall_cnt)
   );

   // in  = {valid, memrd, memwr, ack, bbeq, bbne, bblez, bbgtz, jump, zero, negative}
   // exp = {dmem_req, dmem_we, pcsrc[1:0], flush}
   typedef struct {
      logic [10:0] in;
      logic [4:0]  exp;
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [10:0] v);
      {exmem_valid, memrd, memwr, dmem_ack, bbeq, bbne, bblez, bbgtz, jump, zero, negative} = v;
   endtask

   task automatic idle();
      drive(11'b0);
   endtask

   function automatic logic [2:0] flushes();
      return {flush_ifid, flush_idex, flush_exmem};
   endfunction

   initial begin
      int n;
      logic [4:0] e;

      vecs[0]  = '{11'b1000_10000_10, 5'b00_01_1}; // bbeq, zero
      vecs[1]  = '{11'b1000_10000_00, 5'b00_00_0}; // bbeq, nonzero
      vecs[2]  = '{11'b1000_01000_00, 5'b00_01_1}; // bbne, nonzero
      vecs[3]  = '{11'b1000_01000_10, 5'b00_00_0}; // bbne, zero
      vecs[4]  = '{11'b1000_00100_01, 5'b00_01_1}; // bblez, negative
      vecs[5]  = '{11'b1000_00100_00, 5'b00_00_0}; // bblez, positive
      vecs[6]  = '{11'b1000_00010_01, 5'b00_00_0}; // bbgtz, negative
      vecs[7]  = '{11'b1000_00010_00, 5'b00_01_1}; // bbgtz, positive
      vecs[8]  = '{11'b1000_00010_10, 5'b00_00_0}; // bbgtz, zero
      vecs[9]  = '{11'b1000_01001_00, 5'b00_10_1}; // jump beats taken bbne
      vecs[10] = '{11'b0000_00001_00, 5'b00_00_0}; // bubble with jump
      vecs[11] = '{11'b1101_10000_10, 5'b10_01_1}; // zero-wait load + taken bbeq
      vecs[12] = '{11'b1011_00000_00, 5'b11_00_0}; // zero-wait store
      vecs[13] = '{11'b0100_00000_00, 5'b00_00_0}; // bubble with memrd

      // Reset state, with a load presented to show the request is gated.
      rst = 1'b1;
      dmem_rdata = '0;
      drive(11'b1100_00000_00);
      #2;
      check("rst_req", dmem_req, 0);
      check("rst_stall", stall, 0);
      check("rst_pcsrc", pcsrc, 0);
      check("rst_flush", flushes(), 0);
      check("rst_bus_err", bus_err, 0);
      check("rst_rdata_q", rdata_q, 0);
      check("rst_stall_cnt", stall_cnt, 0);

      @(negedge clk);
      rst = 1'b0;
      idle();

      // Zero-wait load.
      @(negedge clk);
      drive(11'b1101_00000_00);
      dmem_rdata = 32'hDEADBEEF;
      #1;
      check("zw_load_req", dmem_req, 1);
      check("zw_load_we", dmem_we, 0);
      check("zw_load_stall", stall, 0);
      @(negedge clk);
      idle();
      #1;
      check("zw_load_req_drop", dmem_req, 0);
      check("zw_load_rdata_q", rdata_q, 32'hDEADBEEF);
      check("zw_load_stall_cnt", stall_cnt, 0);

      // Store acked on the third cycle after the request.
      @(negedge clk);
      drive(11'b1010_00000_00);
      #1;
      check("st_req", dmem_req, 1);
      check("st_we", dmem_we, 1);
      check("st_stall0", stall, 1);
      n = 1;
      for (int c = 1; c < 10; c++) begin
         @(negedge clk);
         dmem_ack = (c == 3);
         #1;
         if (!stall) break;
         n++;
      end
      check("st_stall_cycles", n, 3);
      check("st_done_req", dmem_req, 1);
      @(negedge clk);
      idle();
      #1;
      check("st_idle_req", dmem_req, 0);
      check("st_idle_stall", stall, 0);
      check("st_stall_cnt", stall_cnt, 3);

      // Store carrying a taken bbeq: branch waits for the un-stalled completion cycle.
      @(negedge clk);
      drive(11'b1010_10000_10);
      #1;
      check("mb_stall", stall, 1);
      check("mb_pcsrc_stalled", pcsrc, 2'b00);
      check("mb_flush_stalled", flushes(), 3'b000);
      @(negedge clk);
      dmem_ack = 1'b1;
      #1;
      check("mb_done_stall", stall, 0);
      check("mb_done_pcsrc", pcsrc, 2'b01);
      check("mb_done_flush", flushes(), 3'b111);
      @(negedge clk);
      idle();
      #1;
      check("mb_flush_pulse", flushes(), 3'b000);
      check("mb_stall_cnt", stall_cnt, 4);

      // memrd and memwr together behave as a store.
      @(negedge clk);
      drive(11'b1111_00000_00);
      dmem_rdata = 32'hCAFEF00D;
      #1;
      check("rw_we", dmem_we, 1);
      check("rw_stall", stall, 0);
      @(negedge clk);
      idle();
      #1;
      check("rw_rdata_q_kept", rdata_q, 32'hDEADBEEF);

      // Zero-wait vector table.
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         drive(vecs[i].in);
         dmem_rdata = 32'h1111_0000 + i;
         e = vecs[i].exp;
         #1;
         check($sformatf("vec%0d_req", i), dmem_req, e[4]);
         check($sformatf("vec%0d_we", i), dmem_we, e[3]);
         check($sformatf("vec%0d_pcsrc", i), pcsrc, e[2:1]);
         check($sformatf("vec%0d_flush", i), flushes(), {3{e[0]}});
         check($sformatf("vec%0d_stall", i), stall, 0);
      end
      @(negedge clk);
      idle();
      #1;
      check("vec_stall_cnt", stall_cnt, 4);

      // Load never acked: timeout into ERR.
      @(negedge clk);
      drive(11'b1100_00000_00);
      n = 0;
      for (int c = 0; c < 40; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         if (!stall) break;
         n++;
      end
      check("to_stall_cycles", n, TIMEOUT);
      check("to_bus_err", bus_err, 1);
      check("to_req", dmem_req, 0);
      check("to_stall_cnt", stall_cnt, 4 + TIMEOUT);
      @(negedge clk);
      idle();
      repeat (3) @(negedge clk);
      #1;
      check("to_bus_err_sticky", bus_err, 1);
      drive(11'b1000_10000_10);
      #1;
      check("err_branch_pcsrc", pcsrc, 2'b01);
      check("err_branch_flush", flushes(), 3'b111);
      @(negedge clk);
      drive(11'b1100_00000_00);
      #1;
      check("err_load_req", dmem_req, 0);
      check("err_load_stall", stall, 0);
      check("err_bus_err", bus_err, 1);
      #2;
      rst = 1'b1;
      #1;
      check("err_rst_bus_err", bus_err, 0);
      check("err_rst_stall_cnt", stall_cnt, 0);

      // Reset asserted mid-access in WAIT; a late ack is ignored.
      @(negedge clk);
      rst = 1'b0;
      idle();
      @(negedge clk);
      drive(11'b1100_00000_00);
      #1;
      check("rw_first_stall", stall, 1);
      @(negedge clk);
      #1;
      check("rw_wait_req", dmem_req, 1);
      check("rw_wait_stall", stall, 1);
      #1;
      rst = 1'b1;
      #1;
      check("rw_rst_req", dmem_req, 0);
      check("rw_rst_stall", stall, 0);
      check("rw_rst_stall_cnt", stall_cnt, 0);
      dmem_ack   = 1'b1;
      dmem_rdata = 32'hBAADF00D;
      @(negedge clk);
      rst = 1'b0;
      drive(11'b0001_00000_00);
      @(negedge clk);
      idle();
      #1;
      check("rw_late_ack_rdata_q", rdata_q, 0);
      check("rw_late_ack_req", dmem_req, 0);
      check("rw_late_ack_bus_err", bus_err, 0);
      check("rw_late_ack_stall_cnt", stall_cnt, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
